// File: rtl/encoder_8x3.sv
// Registered 8-to-3 priority encoder with sticky request buffering and a
// valid/ready output register; return path for decoder_3x8.
module encoder_8x3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       d4,
  input  logic       d5,
  input  logic       d6,
  input  logic       d7,
  output logic [2:0] s,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] d_vec, d_q, evt;
  logic [7:0] clr, pending_nxt;
  logic [2:0] win, s_nxt;
  logic       overflow_nxt;

  assign d_vec = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign evt   = d_vec & ~d_q;
  assign valid = (state == FULL);

  // Ascending scan: the last set bit seen is the highest index, so d7 wins.
  always_comb begin
    win = '0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) win = 3'(i);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_nxt = state;
    s_nxt     = s;
    clr       = '0;
    case (state)
      EMPTY: begin
        if (|pending) begin
          state_nxt = FULL;
          s_nxt     = win;
          clr       = 8'(1) << win;
        end
      end
      FULL: begin
        if (ready) begin
          if (|pending) begin
            s_nxt = win;
            clr   = 8'(1) << win;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
    endcase
    // Overflow and the clear both look at pre-edge pending, so a fresh edge
    // on the bit being loaded simply re-arms it.
    pending_nxt  = (pending & ~clr) | (enable ? evt : 8'h00);
    overflow_nxt = overflow | (enable & (|(evt & pending)));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      s        <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      d_q      <= '0;
    end else begin
      state    <= state_nxt;
      s        <= s_nxt;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
      d_q      <= d_vec;
    end
  end

endmodule

// File: tb/tb_encoder_8x3.sv
// Self-checking bench for encoder_8x3: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] dv = 8'h00;
  logic [2:0] s;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] m_dq = 8'h00;
  logic [7:0] m_pend = 8'h00;
  logic       m_valid = 1'b0;
  logic [2:0] m_s = 3'd0;
  logic       m_ovf = 1'b0;

  encoder_8x3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .d0       (dv[0]),
    .d1       (dv[1]),
    .d2       (dv[2]),
    .d3       (dv[3]),
    .d4       (dv[4]),
    .d5       (dv[5]),
    .d6       (dv[6]),
    .d7       (dv[7]),
    .s        (s),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Advance the model by one edge from the current inputs, then let the DUT
  // take the same edge and settle.
  task automatic step();
    logic [7:0] ev, clr;
    int hi;
    if (!rst_n) begin
      m_dq = 8'h00; m_pend = 8'h00; m_valid = 1'b0; m_s = 3'd0; m_ovf = 1'b0;
    end else begin
      ev  = dv & ~m_dq;
      clr = 8'h00;
      if (!m_valid || ready) begin
        hi = highest(m_pend);
        if (hi >= 0) begin
          m_s     = 3'(hi);
          m_valid = 1'b1;
          clr     = 8'(1 << hi);
        end else begin
          m_valid = 1'b0;
        end
      end
      if (enable && ((ev & m_pend) != 0)) m_ovf = 1'b1;
      m_pend = (m_pend & ~clr) | (enable ? ev : 8'h00);
      m_dq   = dv;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; ready = 1'b1; dv = 8'hFF;
    step(); step();
    checks++;
    if ({s, valid, pending, overflow} !== 13'h0) begin
      errors++;
      $display("FAIL reset_state: s=%0d valid=%0b pending=%h ovf=%0b, want all zero",
               s, valid, pending, overflow);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (pending !== 8'hFF || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: pending=%h valid=%0b, want pending=ff valid=0",
               pending, valid);
    end
    dv = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      step();
      checks++;
      if (valid !== 1'b1 || s !== 3'(i)) begin
        errors++;
        $display("FAIL reset_drain: valid=%0b s=%0d, want valid=1 s=%0d", valid, s, i);
      end
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drain_end: valid=%0b, want 0", valid);
    end
  endtask

  task automatic test_single();
    enable = 1'b1; ready = 1'b1; dv = 8'h00;
    step();
    dv = 8'h20;
    step();
    checks++;
    if (pending !== 8'h20 || valid !== 1'b0) begin
      errors++;
      $display("FAIL single_capture: pending=%h valid=%0b, want 20/0", pending, valid);
    end
    dv = 8'h00;
    step();
    checks++;
    if (valid !== 1'b1 || s !== 3'd5 || pending !== 8'h00) begin
      errors++;
      $display("FAIL single_offer: valid=%0b s=%0d pending=%h, want 1/5/00", valid, s, pending);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: valid=%0b, want 0", valid);
    end
  endtask

  task automatic test_priority();
    logic [2:0] seq [3] = '{3'd7, 3'd4, 3'd0};
    ready = 1'b1;
    dv = 8'h91;
    step();
    dv = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || s !== seq[i]) begin
        errors++;
        $display("FAIL priority_seq%0d: valid=%0b s=%0d, want 1/%0d", i, valid, s, seq[i]);
      end
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL priority_end: valid=%0b, want 0", valid);
    end
  endtask

  task automatic test_back_to_back_backpressure();
    ready = 1'b0;
    dv = 8'h02; step();
    dv = 8'h00; step();
    dv = 8'h40; step();
    dv = 8'h00; step(); step();
    checks++;
    if (valid !== 1'b1 || s !== 3'd1 || pending !== 8'h40) begin
      errors++;
      $display("FAIL bp_hold: valid=%0b s=%0d pending=%h, want 1/1/40", valid, s, pending);
    end
    ready = 1'b1;
    step();
    checks++;
    if (valid !== 1'b1 || s !== 3'd6 || pending !== 8'h00) begin
      errors++;
      $display("FAIL bp_next: valid=%0b s=%0d pending=%h, want 1/6/00", valid, s, pending);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: valid=%0b, want 0", valid);
    end
  endtask

  task automatic test_overflow_enable();
    ready = 1'b0; enable = 1'b1;
    dv = 8'h08; step();
    dv = 8'h00; step();
    dv = 8'h04; step();
    dv = 8'h00; step();
    checks++;
    if (overflow !== 1'b0 || s !== 3'd3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pre: ovf=%0b s=%0d valid=%0b, want 0/3/1", overflow, s, valid);
    end
    dv = 8'h04; step();
    dv = 8'h00; step();
    checks++;
    if (pending !== 8'h04 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: pending=%h ovf=%0b, want 04/1", pending, overflow);
    end
    enable = 1'b0;
    dv = 8'h08; step();
    dv = 8'h00; step();
    checks++;
    if (pending !== 8'h04 || s !== 3'd3 || valid !== 1'b1) begin
      errors++;
      $display("FAIL enable_off: pending=%h s=%0d valid=%0b, want 04/3/1", pending, s, valid);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_midop();
    // Drain to empty, then build valid=1 with pending=0A.
    ready = 1'b1; dv = 8'h00;
    step(); step(); step();
    ready = 1'b0;
    dv = 8'h01; step();
    dv = 8'h00; step();
    dv = 8'h0A; step();
    dv = 8'h00;
    checks++;
    if (valid !== 1'b1 || pending !== 8'h0A || overflow !== 1'b1) begin
      errors++;
      $display("FAIL midop_setup: valid=%0b pending=%h ovf=%0b, want 1/0a/1",
               valid, pending, overflow);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({s, valid, pending, overflow} !== 13'h0) begin
      errors++;
      $display("FAIL midop_reset: s=%0d valid=%0b pending=%h ovf=%0b, want all zero",
               s, valid, pending, overflow);
    end
  endtask

  task automatic test_random();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      dv     = 8'($urandom);
      enable = ($urandom_range(7) != 0);
      ready  = $urandom_range(1);
      rst_n  = ($urandom_range(99) != 0);
      step();
      checks++;
      if ({s, valid, pending, overflow} !== {m_s, m_valid, m_pend, m_ovf}) begin
        errors++;
        $display("FAIL random_cyc%0d: s=%0d valid=%0b pending=%h ovf=%0b, want s=%0d valid=%0b pending=%h ovf=%0b",
                 n, s, valid, pending, overflow, m_s, m_valid, m_pend, m_ovf);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_back_to_back_backpressure();
    test_overflow_enable();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
